// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Instruction sequencer sitting directly upstream of the register file and
// the ALU. It takes one 16-bit instruction at a time, reads the source
// registers, presents operands and opcode to the ALU, and writes the result
// back. The FSM is cycle-exact and every output is a flop.
//
// Instruction word:
//   [15:14] kind : 00 ALU, 01 LDI, 10 NOP, 11 HALT
//   ALU : op=[13:11] dst=[10:9] srcA=[8:7] srcB=[6:5]
//   LDI : dst=[10:9] imm=[7:0]
//
// Optional build macro:
//   CU_SAME_SRC_EN - an ALU instruction whose two sources are the same
//                    register does a single read (RDA -> EXEC, skipping RDB).
//                    Without it both reads are always performed.
//
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   instr_i            instruction word
//   instr_valid_i      instr_i valid
//   instr_ready_o      block can accept an instruction
//   reg_addr_o         register file address
//   reg_rd_o           register read strobe
//   reg_wr_o           register write strobe
//   reg_wdata_o        register write data
//   reg_rdata_i        register read data, sampled on the edge ending a
//                      cycle with reg_rd_o=1
//   alu_opcode_o       ALU opcode (held outside EXEC)
//   alu_a_o, alu_b_o   ALU operands (held outside EXEC)
//   alu_result_i       combinational ALU result
//   done_o             one-cycle pulse, instruction retired
//   result_o           value of the last register write, held
//   halted_o           HALT executed; only reset leaves this state
//   dbg_state_o        current FSM state, for observation
//
// Handshake: an instruction transfers on a rising edge where instr_valid_i=1
// and instr_ready_o=1. It is latched on that edge, so instr_i may change
// afterwards. instr_valid_i while instr_ready_o=0 is ignored; the source
// holds the instruction until it is accepted.
// ---------------------------------------------------------------------------
module control_unit #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   instr_i,
  input  logic          instr_valid_i,
  output logic          instr_ready_o,
  output logic [AW-1:0] reg_addr_o,
  output logic          reg_rd_o,
  output logic          reg_wr_o,
  output logic [DW-1:0] reg_wdata_o,
  input  logic [DW-1:0] reg_rdata_i,
  output logic [2:0]    alu_opcode_o,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  input  logic [DW-1:0] alu_result_i,
  output logic          done_o,
  output logic [DW-1:0] result_o,
  output logic          halted_o,
  output logic [2:0]    dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RDA    = 3'd1,
    S_RDB    = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [1:0] K_ALU  = 2'b00;
  localparam logic [1:0] K_LDI  = 2'b01;
  localparam logic [1:0] K_NOP  = 2'b10;
  localparam logic [1:0] K_HALT = 2'b11;

`ifdef CU_SAME_SRC_EN
  localparam bit SAME_SRC_SKIP = 1'b1;
`else
  localparam bit SAME_SRC_SKIP = 1'b0;
`endif

  // State and registered outputs
  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    opcode_q, opcode_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic          done_q, done_d;
  logic [DW-1:0] result_q, result_d;
  logic          halted_q, halted_d;

  // Internal latches
  logic [15:0]   instr_q, instr_d;
  logic [DW-1:0] a_lat_q, a_lat_d;

  // In IDLE the fields are decoded straight from instr_i so the first
  // sequencing step is registered on the accept edge itself; afterwards
  // they come from the latched copy.
  logic [15:0] cur_instr;
  logic [1:0]  f_kind;
  logic [2:0]  f_op;
  logic [1:0]  f_dst;
  logic [1:0]  f_src_a;
  logic [1:0]  f_src_b;
  logic [7:0]  f_imm;

  assign cur_instr = (state_q == S_IDLE) ? instr_i : instr_q;
  assign f_kind    = cur_instr[15:14];
  assign f_op      = cur_instr[13:11];
  assign f_dst     = cur_instr[10:9];
  assign f_src_a   = cur_instr[8:7];
  assign f_src_b   = cur_instr[6:5];
  assign f_imm     = cur_instr[7:0];

  always_comb begin
    // Pulses and strobes default low; data outputs and latches hold.
    state_d  = state_q;
    ready_d  = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    done_d   = 1'b0;
    halted_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    opcode_d = opcode_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    instr_d  = instr_q;
    a_lat_d  = a_lat_q;

    case (state_q)
      S_IDLE: begin
        // ready_q is still 0 in the first cycle after reset release, so
        // nothing is accepted there even though the state is already IDLE.
        if (instr_valid_i && ready_q) begin
          instr_d = instr_i;
          case (f_kind)
            K_ALU: begin
              state_d = S_RDA;
              rd_d    = 1'b1;
              addr_d  = AW'(f_src_a);
            end
            K_LDI: begin
              state_d  = S_WB;
              wr_d     = 1'b1;
              addr_d   = AW'(f_dst);
              wdata_d  = DW'(f_imm);
              result_d = DW'(f_imm);
              done_d   = 1'b1;
            end
            K_NOP: begin
              state_d = S_WB;
              done_d  = 1'b1;
            end
            default: begin
              state_d  = S_HALTED;
              halted_d = 1'b1;
            end
          endcase
        end else begin
          ready_d = 1'b1;
        end
      end

      S_RDA: begin
        // reg_rdata_i now carries srcA.
        a_lat_d = reg_rdata_i;
        if (SAME_SRC_SKIP && (f_src_a == f_src_b)) begin
          state_d  = S_EXEC;
          opcode_d = f_op;
          alu_a_d  = reg_rdata_i;
          alu_b_d  = reg_rdata_i;
        end else begin
          state_d = S_RDB;
          rd_d    = 1'b1;
          addr_d  = AW'(f_src_b);
        end
      end

      S_RDB: begin
        // reg_rdata_i now carries srcB; it is the B latch and goes straight
        // to the operand flop.
        state_d  = S_EXEC;
        opcode_d = f_op;
        alu_a_d  = a_lat_q;
        alu_b_d  = reg_rdata_i;
      end

      S_EXEC: begin
        state_d  = S_WB;
        wr_d     = 1'b1;
        addr_d   = AW'(f_dst);
        wdata_d  = alu_result_i;
        result_d = alu_result_i;
        done_d   = 1'b1;
      end

      S_WB: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end

      S_HALTED: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      opcode_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      halted_q <= 1'b0;
      instr_q  <= '0;
      a_lat_q  <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      opcode_q <= opcode_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      done_q   <= done_d;
      result_q <= result_d;
      halted_q <= halted_d;
      instr_q  <= instr_d;
      a_lat_q  <= a_lat_d;
    end
  end

  assign instr_ready_o = ready_q;
  assign reg_addr_o    = addr_q;
  assign reg_rd_o      = rd_q;
  assign reg_wr_o      = wr_q;
  assign reg_wdata_o   = wdata_q;
  assign alu_opcode_o  = opcode_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign done_o        = done_q;
  assign result_o      = result_q;
  assign halted_o      = halted_q;
  assign dbg_state_o   = state_q;

endmodule
